// File: rtl/pulse_pacer.sv
// Source-domain pacer that sits in front of the single-pulse CDC synchronizer.
// It counts incoming event strobes and re-emits them at least MIN_GAP clocks apart.
module pulse_pacer #(
    parameter int MIN_GAP   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 in_pulse,
    output logic                 out_pulse,
    output logic [CNT_WIDTH-1:0] pending,
    output logic                 overflow,
    output logic                 busy
);

    localparam int                   GAP_WIDTH  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_WIDTH-1:0] GAP_RELOAD = GAP_WIDTH'(MIN_GAP - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic [GAP_WIDTH-1:0] gap_cnt;
    logic                 fire;
    logic [CNT_WIDTH-1:0] pending_next;
    logic                 overflow_next;

    // An event arriving while idle fires directly and never enters the counter.
    assign fire = ((pending != '0) || in_pulse) && (gap_cnt == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        pending_next  = pending;
        overflow_next = 1'b0;
        case ({in_pulse, fire})
            2'b10: begin
                if (pending == CNT_MAX) begin
                    overflow_next = 1'b1;
                end else begin
                    pending_next = pending + CNT_WIDTH'(1);
                end
            end
            2'b01:   pending_next = pending - CNT_WIDTH'(1);
            default: pending_next = pending;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_pulse <= 1'b0;
            overflow  <= 1'b0;
            pending   <= '0;
            gap_cnt   <= '0;
        end else begin
            out_pulse <= fire;
            overflow  <= overflow_next;
            pending   <= pending_next;
            if (fire) begin
                gap_cnt <= GAP_RELOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
        end
    end

    assign busy = (pending != '0) || (gap_cnt != '0);

endmodule

// File: tb/tb_pulse_pacer.sv
// Scoreboard bench for pulse_pacer: a time-based reference model queues expected
// outputs per clock edge, and an independent monitor pops and compares them.
module tb_pulse_pacer;

    localparam int MIN_GAP   = 4;
    localparam int CNT_WIDTH = 3;
    localparam int CAP       = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_pulse = 1'b0;
    logic                 out_pulse;
    logic [CNT_WIDTH-1:0] pending;
    logic                 overflow;
    logic                 busy;

    pulse_pacer #(.MIN_GAP(MIN_GAP), .CNT_WIDTH(CNT_WIDTH)) dut (
        .reset    (reset),
        .clk      (clk),
        .in_pulse (in_pulse),
        .out_pulse(out_pulse),
        .pending  (pending),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                 out;
        logic [CNT_WIDTH-1:0] pend;
        logic                 ovf;
        logic                 busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: emissions allowed once MIN_GAP edges have elapsed since the last one.
    int     m_pend;
    longint m_edge;
    longint m_last_fire;
    int     m_in_total;
    int     m_ovf_total;

    // Monitor-side bookkeeping
    exp_t   mon_e;
    int     dut_out_total = 0;
    longint mon_cycle     = 0;
    longint mon_last_out  = -1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_pend      = 0;
        m_edge      = 0;
        m_last_fire = -1000;
        m_in_total  = 0;
        m_ovf_total = 0;
    endtask

    task automatic model_step(input logic in, output exp_t e);
        bit can_emit, f, ovf;
        can_emit = (m_edge - m_last_fire) >= MIN_GAP;
        f        = ((m_pend + int'(in)) > 0) && can_emit;
        ovf      = 1'b0;
        if (f) m_last_fire = m_edge;
        if (in && !f && m_pend == CAP) ovf = 1'b1;
        else m_pend = m_pend + int'(in) - int'(f);
        e.out  = f;
        e.pend = CNT_WIDTH'(m_pend);
        e.ovf  = ovf;
        e.busy = (m_pend != 0) || ((m_edge - m_last_fire) < MIN_GAP - 1);
        m_in_total  += int'(in);
        m_ovf_total += int'(ovf);
        m_edge++;
    endtask

    // One clock of stimulus: drive, model the edge, queue the expectation.
    task automatic drive_cycle(input logic v);
        exp_t e;
        in_pulse = v;
        @(posedge clk);
        model_step(v, e);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic drive_pattern(input int n, input int pct);
        for (int i = 0; i < n; i++) drive_cycle($urandom_range(0, 99) < pct);
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy && pending == '0 && exp_q.size() == 0 && !out_pulse) break;
            drive_cycle(1'b0);
        end
        check({tag, "_drained_busy"}, busy, 0);
        check({tag, "_conservation"}, dut_out_total, m_in_total - m_ovf_total);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            dut_out_total = 0;
            mon_cycle     = 0;
            mon_last_out  = -1;
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("out_pulse", out_pulse, mon_e.out);
            check("pending",   pending,   mon_e.pend);
            check("overflow",  overflow,  mon_e.ovf);
            check("busy",      busy,      mon_e.busy);
            if (out_pulse) begin
                if (mon_last_out >= 0)
                    check("min_spacing", longint'((mon_cycle - mon_last_out) >= MIN_GAP), 1);
                mon_last_out = mon_cycle;
                dut_out_total++;
            end
            mon_cycle++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #1;
        check("reset_out_pulse", out_pulse, 0);
        check("reset_pending",   pending,   0);
        check("reset_overflow",  overflow,  0);
        check("reset_busy",      busy,      0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;

        // Single event, then idle long enough to see the full busy window
        drive_cycle(1'b1);
        repeat (6) drive_cycle(1'b0);

        // Five back-to-back events
        repeat (5) drive_cycle(1'b1);
        repeat (4) drive_cycle(1'b0);
        // Coincidence: arrival on the fire edge while pending is nonzero
        drive_cycle(1'b1);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b1);

        // Long burst to saturate the counter, then random heavy traffic
        repeat (14) drive_cycle(1'b1);
        drive_pattern(300, 45);
        drain_and_check("phase1");

        // Build pending=5 with gap timer at 2, then reset mid-cycle
        repeat (7) drive_cycle(1'b1);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b1);
        #2;
        reset    = 1'b0;
        in_pulse = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_out_pulse", out_pulse, 0);
        check("midreset_pending",   pending,   0);
        check("midreset_overflow",  overflow,  0);
        check("midreset_busy",      busy,      0);
        repeat (2) @(negedge clk);
        #1;
        check("held_reset_out_pulse", out_pulse, 0);
        model_reset();
        reset = 1'b1;

        drive_cycle(1'b1);
        repeat (6) drive_cycle(1'b0);
        drive_pattern(300, 15);
        drive_pattern(100, 60);
        drain_and_check("phase2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
